// File: rtl/ad9363_tx_scheduler.sv
// ---------------------------------------------------------------------------
// ad9363_tx_scheduler
//   Sample scheduler in front of the AD9363 LVDS TX serializer. It buffers I/Q
//   words from a valid/ready stream, or generates a ramp, and strobes
//   dac_valid at the serializer's consumption cadence: every 2 cycles in
//   1R1T and every 4 cycles in 2R2T. The TX mode is latched when a burst
//   starts, and empty-FIFO issue slots are counted as underflows.
//
// Ports
//   fb_clk, rst_n        feedback clock (rising edge), async active-low reset
//   enable               run request (level)
//   mode_1r1t            requested mode (1 = 1R1T), latched when leaving IDLE
//   src_sel              sample source per issue: 0 = FIFO, 1 = ramp
//   flush                empties the FIFO; acted on only in IDLE
//   s_valid/s_ready      stream handshake; s_ready = !full
//   s_data[47:0]         {i0, q0, i1, q1}, 12 bits each
//   underflow_clr        clears underflow_cnt; wins over a same-cycle underflow
//   mode_1r1t_out        latched mode for the TX interface
//   dac_valid            one-cycle sample strobe
//   dac_data_i0/q0/i1/q1 sample data, held between strobes
//   underflow_cnt[15:0]  saturating underflow count
//   busy                 high whenever the scheduler is not IDLE
// ---------------------------------------------------------------------------
module ad9363_tx_scheduler #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        fb_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        mode_1r1t,
    input  logic        src_sel,
    input  logic        flush,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [47:0] s_data,
    input  logic        underflow_clr,
    output logic        mode_1r1t_out,
    output logic        dac_valid,
    output logic [11:0] dac_data_i0,
    output logic [11:0] dac_data_q0,
    output logic [11:0] dac_data_i1,
    output logic [11:0] dac_data_q1,
    output logic [15:0] underflow_cnt,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_HALF = (AW + 1)'(FIFO_DEPTH / 2);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    slot_q, slot_d;
    logic [11:0]   ramp_q, ramp_d;
    logic          mode_q, mode_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [47:0]   mem_q [FIFO_DEPTH];
    logic          dac_valid_q;
    logic [47:0]   dac_word_q;
    logic [15:0]   underflow_cnt_q, underflow_d;

    logic          fifo_empty, flush_eff, push, pop, issue, last_slot, underflow_ev;
    logic [11:0]   ramp_hi;
    logic [47:0]   issue_word;

    // ---------------- FIFO handshake and issue decode ----------------------
    assign fifo_empty   = (count_q == '0);
    assign s_ready      = (count_q != CNT_FULL);
    assign flush_eff    = flush && (state_q == ST_IDLE);
    assign push         = s_valid && s_ready && !flush_eff;
    assign issue        = (state_q == ST_RUN) && (slot_q == 2'd0);
    // Emptiness comes from the registered count, so a word written this cycle
    // is not visible to a pop until the next one.
    assign pop          = issue && !src_sel && !fifo_empty;
    assign underflow_ev = issue && !src_sel && fifo_empty;
    assign last_slot    = (slot_q == (mode_q ? 2'd1 : 2'd3));

    // ---------------- Scheduler state machine -----------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        ramp_d  = ramp_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                slot_d = 2'd0;
                ramp_d = 12'd0;
                if (enable) begin
                    mode_d  = mode_1r1t;
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (src_sel || (count_q >= CNT_HALF)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                slot_d = last_slot ? 2'd0 : slot_q + 2'd1;
                // Stopping only at the last slot lets a committed issue
                // finish its full period.
                if (!enable && last_slot) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue && src_sel) begin
            ramp_d = ramp_q + 12'd1;
        end
    end

    // ---------------- FIFO pointers / count -------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_eff) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // ---------------- Issue data and underflow counter --------------------
    always_comb begin
        ramp_hi = ramp_q + 12'h800;
        if (src_sel) begin
            issue_word = {ramp_q, ~ramp_q, ramp_hi, ~ramp_hi};
        end else if (!fifo_empty) begin
            issue_word = mem_q[rd_ptr_q];
        end else begin
            issue_word = '0;
        end

        underflow_d = underflow_cnt_q;
        if (underflow_clr) begin
            underflow_d = '0;
        end else if (underflow_ev && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_d = underflow_cnt_q + 16'd1;
        end
    end

    // NOTE: the storage array has no reset; stale contents are never read
    // because the count and pointers are reset, and a reset-free array maps
    // onto plain RAM.
    always_ff @(posedge fb_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge fb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            slot_q          <= 2'd0;
            ramp_q          <= 12'd0;
            mode_q          <= 1'b0;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            dac_valid_q     <= 1'b0;
            dac_word_q      <= '0;
            underflow_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            ramp_q          <= ramp_d;
            mode_q          <= mode_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            dac_valid_q     <= issue;
            underflow_cnt_q <= underflow_d;
            if (issue) begin
                dac_word_q <= issue_word;
            end
        end
    end

    // ---------------- Outputs ---------------------------------------------
    assign mode_1r1t_out = mode_q;
    assign dac_valid     = dac_valid_q;
    assign dac_data_i0   = dac_word_q[47:36];
    assign dac_data_q0   = dac_word_q[35:24];
    assign dac_data_i1   = dac_word_q[23:12];
    assign dac_data_q1   = dac_word_q[11:0];
    assign underflow_cnt = underflow_cnt_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ad9363_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ad9363_tx_scheduler
//   Self-checking bench for ad9363_tx_scheduler. A transaction-level model
//   (a word queue, a ramp integer and an underflow tally) predicts every
//   strobe's data; the strobe schedule follows from the start-up latency and
//   the period P of the burst mode.
// ---------------------------------------------------------------------------
module tb_ad9363_tx_scheduler;

    localparam int DEPTH = 8;

    logic        fb_clk = 1'b0;
    logic        rst_n;
    logic        enable, mode_1r1t, src_sel, flush, s_valid, underflow_clr;
    logic [47:0] s_data;
    logic        s_ready, mode_1r1t_out, dac_valid, busy;
    logic [11:0] dac_data_i0, dac_data_q0, dac_data_i1, dac_data_q1;
    logic [15:0] underflow_cnt;

    ad9363_tx_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .fb_clk        (fb_clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .mode_1r1t     (mode_1r1t),
        .src_sel       (src_sel),
        .flush         (flush),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .underflow_clr (underflow_clr),
        .mode_1r1t_out (mode_1r1t_out),
        .dac_valid     (dac_valid),
        .dac_data_i0   (dac_data_i0),
        .dac_data_q0   (dac_data_q0),
        .dac_data_i1   (dac_data_i1),
        .dac_data_q1   (dac_data_q1),
        .underflow_cnt (underflow_cnt),
        .busy          (busy)
    );

    always #5 fb_clk = ~fb_clk;

    // ---------------- Reference model state --------------------------------
    logic [47:0] q[$];          // words accepted and not yet issued
    int          r;             // ramp value for the next ramp issue
    int          ucnt;          // expected underflow count
    logic        exp_mode;
    logic [11:0] e_i0, e_q0, e_i1, e_q1;
    int          clr_k = -1;    // issue index that also pulses underflow_clr
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] rnd;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict, advance past the edge, then compare everything.
    task automatic tick(input bit is_issue);
        bit          acc, clr, src;
        logic [47:0] w, head;
        int          hi;
        check("s_ready", 48'(s_ready), 48'(q.size() < DEPTH));
        acc = s_valid && (q.size() < DEPTH);
        w   = s_data;
        clr = underflow_clr;
        src = src_sel;
        @(posedge fb_clk);
        #1;
        if (is_issue) begin
            if (src) begin
                hi   = (r + 2048) % 4096;
                e_i0 = 12'(r);
                e_q0 = 12'(4095 - r);
                e_i1 = 12'(hi);
                e_q1 = 12'(4095 - hi);
                r    = (r + 1) % 4096;
            end else if (q.size() > 0) begin
                head = q.pop_front();
                e_i0 = head[47:36];
                e_q0 = head[35:24];
                e_i1 = head[23:12];
                e_q1 = head[11:0];
            end else begin
                e_i0 = '0; e_q0 = '0; e_i1 = '0; e_q1 = '0;
                if (ucnt < 65535) ucnt++;
            end
        end
        if (clr) ucnt = 0;
        if (acc) q.push_back(w);
        check("dac_valid",     48'(dac_valid),     48'(is_issue));
        check("dac_data_i0",   48'(dac_data_i0),   48'(e_i0));
        check("dac_data_q0",   48'(dac_data_q0),   48'(e_q0));
        check("dac_data_i1",   48'(dac_data_i1),   48'(e_i1));
        check("dac_data_q1",   48'(dac_data_q1),   48'(e_q1));
        check("underflow_cnt", 48'(underflow_cnt), 48'(ucnt));
        check("mode_1r1t_out", 48'(mode_1r1t_out), 48'(exp_mode));
    endtask

    task automatic push_word(input logic [47:0] w);
        s_valid = 1'b1;
        s_data  = w;
        tick(1'b0);
        s_valid = 1'b0;
    endtask

    task automatic flush_fifo();
        flush = 1'b1;
        tick(1'b0);
        flush = 1'b0;
        q.delete();
    endtask

    // Drop enable right after an issue edge (slot = 1) and watch the wind-down.
    task automatic stop_burst(input int p);
        enable  = 1'b0;
        s_valid = 1'b0;
        flush   = 1'b0;
        for (int j = 1; j < p; j++) begin
            tick(1'b0);
            check("busy_stop", 48'(busy), 48'(j < p - 1));
        end
        tick(1'b0);
        tick(1'b0);
        check("busy_idle", 48'(busy), 48'(0));
    endtask

    // Burst of n issues. src_sel is held high through PRIME so RUN starts at
    // E1; srcmode 0/1 fixes the source, 2 randomises it per issue. 'wild'
    // toggles mode_1r1t/flush and pushes random words while running.
    task automatic burst(input bit mode, input int n, input int srcmode, input bit wild);
        int p, gap;
        p         = mode ? 2 : 4;
        mode_1r1t = mode;
        src_sel   = 1'b1;
        s_valid   = 1'b0;
        enable    = 1'b1;
        exp_mode  = mode;
        r         = 0;
        tick(1'b0);                              // E0: enter PRIME
        check("busy_prime", 48'(busy), 48'(1));
        tick(1'b0);                              // E1: enter RUN
        for (int k = 0; k < n; k++) begin
            src_sel = (srcmode == 2) ? 1'($urandom_range(0, 1)) : (srcmode == 1);
            gap     = (k == 0) ? 1 : p;
            for (int j = 1; j <= gap; j++) begin
                if (wild) begin
                    mode_1r1t = 1'($urandom_range(0, 1));
                    flush     = 1'($urandom_range(0, 1));
                    s_valid   = 1'($urandom_range(0, 1));
                    rnd       = {$urandom, $urandom};
                    s_data    = rnd[47:0];
                end
                if (j == gap && k == clr_k) underflow_clr = 1'b1;
                tick(j == gap);
                underflow_clr = 1'b0;
            end
        end
        stop_burst(p);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode_1r1t = 1'b0; src_sel = 1'b0;
        flush = 1'b0; s_valid = 1'b0; s_data = '0; underflow_clr = 1'b0;
        ucnt = 0; r = 0; exp_mode = 1'b0;
        e_i0 = '0; e_q0 = '0; e_i1 = '0; e_q1 = '0;

        // ---- reset values ----
        #12;
        check("rst_dac_valid", 48'(dac_valid), 48'(0));
        check("rst_data", {dac_data_i0, dac_data_q0, dac_data_i1, dac_data_q1}, 48'(0));
        check("rst_mode", 48'(mode_1r1t_out), 48'(0));
        check("rst_ucnt", 48'(underflow_cnt), 48'(0));
        check("rst_busy", 48'(busy), 48'(0));
        check("rst_s_ready", 48'(s_ready), 48'(1));
        @(negedge fb_clk);
        rst_n = 1'b1;
        @(posedge fb_clk);
        #1;

        // ---- 2R2T stream: 4 words, then an underflow on the 5th slot ----
        push_word(48'h001002003004);
        push_word(48'h005006007008);
        push_word(48'h00900A00B00C);
        push_word(48'h00D00E00F010);
        burst(1'b0, 5, 0, 1'b0);
        check("stream_ucnt", 48'(underflow_cnt), 48'(1));
        check("stream_uf_i0", 48'(dac_data_i0), 48'(0));

        // ---- 1R1T ramp through a full wrap ----
        burst(1'b1, 4097, 1, 1'b0);
        check("ramp_wrap_i0", 48'(dac_data_i0), 48'(0));
        check("ramp_wrap_q0", 48'(dac_data_q0), 48'(12'hFFF));
        check("ramp_wrap_i1", 48'(dac_data_i1), 48'(12'h800));

        // ---- PRIME waits for a half-full FIFO ----
        mode_1r1t = 1'b0; src_sel = 1'b0; enable = 1'b1; exp_mode = 1'b0;
        tick(1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0);
            check("prime_busy", 48'(busy), 48'(1));
        end
        for (int i = 0; i < DEPTH / 2; i++) begin
            rnd = {$urandom, $urandom};
            push_word(rnd[47:0]);
        end
        tick(1'b0);
        tick(1'b1);
        stop_burst(4);

        // ---- mode latch: toggles mid-burst are ignored ----
        burst(1'b0, 6, 2, 1'b1);
        burst(1'b1, 6, 2, 1'b1);

        // ---- stop on boundary keeps the FIFO; flush empties it ----
        flush_fifo();
        for (int i = 0; i < 6; i++) push_word(48'h100000000000 + 48'(i));
        burst(1'b0, 2, 0, 1'b0);
        for (int i = 0; i < 4; i++) push_word(48'h200000000000 + 48'(i));
        check("retained_full", 48'(s_ready), 48'(0));
        push_word(48'hDEADBEEF0000);
        flush_fifo();
        check("flush_s_ready", 48'(s_ready), 48'(1));
        burst(1'b1, 2, 0, 1'b0);

        // ---- backpressure with enable low ----
        for (int i = 0; i < DEPTH; i++) begin
            rnd = {$urandom, $urandom};
            push_word(rnd[47:0]);
        end
        check("full_s_ready", 48'(s_ready), 48'(0));
        push_word(48'hBAD0BAD0BAD0);
        flush_fifo();

        // ---- underflow saturation and clear priority ----
        force dut.underflow_cnt_q = 16'hFFFD;
        #1;
        release dut.underflow_cnt_q;
        ucnt = 16'hFFFD;
        burst(1'b1, 4, 0, 1'b0);
        check("ucnt_saturated", 48'(underflow_cnt), 48'(16'hFFFF));
        clr_k = 1;
        burst(1'b1, 3, 0, 1'b0);
        clr_k = -1;
        check("ucnt_after_clr", 48'(underflow_cnt), 48'(1));

        // ---- randomised bursts ----
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < $urandom_range(0, DEPTH - q.size()); i++) begin
                rnd = {$urandom, $urandom};
                push_word(rnd[47:0]);
            end
            burst(1'($urandom_range(0, 1)), $urandom_range(1, 10), 2, 1'b1);
        end

        // ---- async reset mid-RUN ----
        push_word(48'h0AA0BB0CC0DD);
        mode_1r1t = 1'b1; src_sel = 1'b1; enable = 1'b1; exp_mode = 1'b1; r = 0;
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dac_valid", 48'(dac_valid), 48'(0));
        check("arst_data", {dac_data_i0, dac_data_q0, dac_data_i1, dac_data_q1}, 48'(0));
        check("arst_mode", 48'(mode_1r1t_out), 48'(0));
        check("arst_ucnt", 48'(underflow_cnt), 48'(0));
        check("arst_busy", 48'(busy), 48'(0));
        enable = 1'b0; src_sel = 1'b0;
        q.delete();
        ucnt = 0; exp_mode = 1'b0;
        e_i0 = '0; e_q0 = '0; e_i1 = '0; e_q1 = '0;
        @(negedge fb_clk);
        rst_n = 1'b1;
        @(posedge fb_clk);
        #1;
        check("arst_s_ready", 48'(s_ready), 48'(1));
        burst(1'b0, 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ad9363_tx_scheduler.md
# ad9363_tx_scheduler

Sample scheduler in front of the AD9363 LVDS transmit interface, running on `fb_clk`. It buffers 2R2T/1R1T I/Q words from a valid/ready user stream, or generates an internal ramp pattern. It issues `dac_valid` strobes at exactly the cadence the LVDS TX serializer consumes: one every 2 cycles in 1R1T, one every 4 cycles in 2R2T. It also latches the TX mode, so the mode can only change between bursts, and it counts underflows.

## Interface
- `FIFO_DEPTH`, 8, stream buffer depth in words; power of 2, at least 4.

- `fb_clk`  in  1  feedback clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request (level).
- `mode_1r1t`  in  1  requested mode: 1 = 1R1T, 0 = 2R2T. Sampled only when leaving IDLE.
- `src_sel`  in  1  sample source: 0 = stream FIFO, 1 = ramp pattern. Sampled at each issue.
- `flush`  in  1  empties the FIFO. Honoured only in IDLE.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  equals `!full`; combinational from the registered FIFO count.
- `s_data`  in  48  stream word: i0[47:36], q0[35:24], i1[23:12], q1[11:0].
- `underflow_clr`  in  1  clears `underflow_cnt`.
- `mode_1r1t_out`  out  1  latched mode; drives the TX interface.
- `dac_valid`  out  1  one-cycle sample strobe.
- `dac_data_i0`, `dac_data_q0`, `dac_data_i1`, `dac_data_q1`  out  12 each  sample data; held between strobes.
- `underflow_cnt`  out  16  saturating count of underflow slots.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
**FIFO**
- `FIFO_DEPTH` entries; writes on `s_valid && s_ready`.
- No fall-through: a word written in a cycle cannot be popped in that same cycle.
- Pops only on a stream-source issue while the FIFO is non-empty.
- Simultaneous push and pop leaves the count unchanged.

**Period**
- P = 2 when `mode_1r1t_out` = 1; P = 4 otherwise.
- The slot counter `slot` runs 0..P-1 and wraps only while in RUN.

**State machine**
- IDLE:
  - `slot` = 0 and the ramp is 0.
  - When `enable` = 1: latch `mode_1r1t` into `mode_1r1t_out` and go to PRIME.
- PRIME:
  - Go to RUN when `src_sel` = 1, or when FIFO count ≥ `FIFO_DEPTH`/2.
  - If `enable` = 0, go to IDLE instead (this takes priority).
- RUN:
  - Issue when `slot` = 0.
  - If `enable` = 0 and `slot` = P-1, go to IDLE.
  - An issue already committed always completes its slot, so a burst ends on a slot boundary.

**Issue**
- Registered outputs update on the following edge, and `dac_valid` is high for that one cycle.
- `src_sel` = 0, FIFO non-empty: pop the head word to the `dac_data_*` outputs.
- `src_sel` = 0, FIFO empty (underflow):
  - `dac_valid` is still pulsed, with all data at 0.
  - `underflow_cnt` increments, saturating at 0xFFFF.
- `src_sel` = 1: outputs are driven from ramp value R, then R increments by 1 (wraps 0xFFF→0x000). The FIFO is untouched.
  - i0 = R
  - q0 = ~R
  - i1 = R+0x800 (mod 4096)
  - q1 = ~(R+0x800)
- In 1R1T, i1/q1 are still driven, but the TX interface ignores them.

**Underflow clear**
- `underflow_clr` takes priority over a simultaneous underflow event; the counter reads 0 afterwards.

**Ignored inputs**
- `mode_1r1t` changes outside IDLE are ignored.
- `flush` outside IDLE is ignored.

## Timing
**Reset values**
- `dac_valid` = 0, all `dac_data_*` = 0, `mode_1r1t_out` = 0, `underflow_cnt` = 0, `busy` = 0.
- FIFO is empty, so `s_ready` = 1.
- State is IDLE.

**Start-up latency**
- The edge sampling `enable` = 1 in IDLE is E0. PRIME is entered at E0.
- If the PRIME condition already holds: RUN at E1, first issue at E1, and `dac_valid` is high in the cycle after E2.
- If the PRIME condition does not hold, issue waits for FIFO count ≥ `FIFO_DEPTH`/2.

**Strobe cadence in RUN**
- `dac_valid` period is exactly P cycles, with no gaps, including across underflows and `src_sel` switches.

**Stop**
- The `dac_valid` pulses issued before `enable` was sampled low are the final pulses; none follow.
- `busy` falls one cycle after the `slot` = P-1 edge.

**Reset mid-burst**
- All outputs go to their reset values immediately.
- FIFO contents and the ramp are discarded.

## Test plan
- **2R2T stream:** `mode_1r1t` = 0; preload 4 words 0x001002003004, 0x005006007008, …; `enable` = 1.
  - Required: `dac_valid` every 4 cycles; first output i0 = 0x001, q0 = 0x002, i1 = 0x003, q1 = 0x004; words out in order.
  - Required: underflow on the 5th slot, giving zero data and `underflow_cnt` = 1.
- **1R1T ramp:** `mode_1r1t` = 1, `src_sel` = 1.
  - Required: `dac_valid` every 2 cycles; i0 = 0, 1, 2, …; q0 = 0xFFF, 0xFFE, …; i1 = 0x800.
  - Required: after 4096 issues, R wraps to 0.
- **Mode latch:** toggle `mode_1r1t` mid-burst.
  - Required: `mode_1r1t_out` and the period stay unchanged until IDLE; the next burst uses the new mode.
- **Stop on boundary:** drop `enable` at `slot` = 1 in 2R2T.
  - Required: no further `dac_valid`; `busy` low after `slot` = 3.
  - Required: FIFO count retained; `flush` then empties it and `s_ready` = 1.
- **Backpressure and counters:** fill to `FIFO_DEPTH` with `enable` = 0.
  - Required: `s_ready` = 0.
  - Force 0xFFFF underflows: counter holds at 0xFFFF.
  - Apply `underflow_clr` together with an underflow event: counter reads 0.
- **Async reset:** assert `rst_n` low mid-RUN.
  - Required: all outputs are 0 in the same cycle; `s_ready` = 1 after release.
